// File: rtl/fpga_ps_cfg_rx.sv
// Passive-serial configuration target: assembles the image shifted in on dclk/data0 and reports
// status_n/conf_done/init_done to the master. Define CFG_RX_CHECKSUM_EN to verify a trailing checksum byte.
module fpga_ps_cfg_rx #(
   parameter int IMAGE_BYTES = 16,
   parameter int RST_DLY     = 8,
   parameter int INIT_CLKS   = 10,
   localparam int CW         = $clog2(IMAGE_BYTES + 1)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          config_n,
   input  logic          dclk,
   input  logic          data0,
   output logic          status_n,
   output logic          conf_done,
   output logic          init_done,
   output logic [7:0]    cfg_byte,
   output logic          cfg_stb,
   output logic [CW-1:0] byte_cnt,
   output logic          cfg_err
);
   localparam int DW = (RST_DLY > 1) ? $clog2(RST_DLY) : 1;
   localparam int IW = (INIT_CLKS > 1) ? $clog2(INIT_CLKS) : 1;

   localparam logic [2:0] ST_RESET = 3'd0;
   localparam logic [2:0] ST_WAIT  = 3'd1;
   localparam logic [2:0] ST_LOAD  = 3'd2;
   localparam logic [2:0] ST_INIT  = 3'd3;
   localparam logic [2:0] ST_USER  = 3'd4;
`ifdef CFG_RX_CHECKSUM_EN
   localparam logic [2:0] ST_ERROR = 3'd5;
`endif

   logic          config_n_s1, config_n_s;
   logic          dclk_s1, dclk_s2;
   logic          data0_s1, data0_s;
   logic          dclk_rise;
   logic [2:0]    state;
   logic [2:0]    bit_cnt;
   logic [6:0]    shreg;
   logic [7:0]    asm_byte;
   logic [DW-1:0] dly;
   logic [IW-1:0] init_cnt;
   logic          last_byte;

`ifdef CFG_RX_CHECKSUM_EN
   logic [7:0]    sum;
   logic          err_q;
   assign cfg_err = err_q;
`else
   assign cfg_err = 1'b0;
`endif

   assign dclk_rise = dclk_s1 & ~dclk_s2;
   // The incoming bit lands in bit7, so after eight shifts the first bit sits in bit0.
   assign asm_byte  = {data0_s, shreg};
   assign last_byte = (byte_cnt == CW'(IMAGE_BYTES - 1));

   always_ff @(posedge clk) begin
      if (rst) begin
         config_n_s1 <= 1'b0;
         config_n_s  <= 1'b0;
         dclk_s1     <= 1'b0;
         dclk_s2     <= 1'b0;
         data0_s1    <= 1'b0;
         data0_s     <= 1'b0;
         state       <= ST_RESET;
         status_n    <= 1'b0;
         conf_done   <= 1'b0;
         init_done   <= 1'b0;
         cfg_byte    <= 8'd0;
         cfg_stb     <= 1'b0;
         byte_cnt    <= '0;
         bit_cnt     <= 3'd0;
         shreg       <= 7'd0;
         dly         <= '0;
         init_cnt    <= '0;
`ifdef CFG_RX_CHECKSUM_EN
         sum         <= 8'd0;
         err_q       <= 1'b0;
`endif
      end else begin
         config_n_s1 <= config_n;
         config_n_s  <= config_n_s1;
         dclk_s1     <= dclk;
         dclk_s2     <= dclk_s1;
         data0_s1    <= data0;
         data0_s     <= data0_s1;
         cfg_stb     <= 1'b0;
         // A low config_n restarts configuration from any state and wins over a same-cycle dclk rise.
         if (!config_n_s) begin
            state     <= ST_RESET;
            status_n  <= 1'b0;
            conf_done <= 1'b0;
            init_done <= 1'b0;
            cfg_byte  <= 8'd0;
            byte_cnt  <= '0;
            bit_cnt   <= 3'd0;
            shreg     <= 7'd0;
            dly       <= '0;
            init_cnt  <= '0;
`ifdef CFG_RX_CHECKSUM_EN
            sum       <= 8'd0;
            err_q     <= 1'b0;
`endif
         end else begin
            case (state)
               ST_RESET: begin
                  status_n <= 1'b0;
                  dly      <= DW'(RST_DLY - 1);
                  state    <= ST_WAIT;
               end
               ST_WAIT: begin
                  if (dly == '0) begin
                     status_n <= 1'b1;
                     state    <= ST_LOAD;
                  end else begin
                     dly <= dly - DW'(1);
                  end
               end
               ST_LOAD: begin
                  if (dclk_rise) begin
                     shreg   <= asm_byte[7:1];
                     bit_cnt <= bit_cnt + 3'd1;
                     if (bit_cnt == 3'd7) begin
                        cfg_byte <= asm_byte;
                        cfg_stb  <= 1'b1;
                        byte_cnt <= byte_cnt + CW'(1);
                        if (last_byte) begin
`ifdef CFG_RX_CHECKSUM_EN
                           if (asm_byte == sum) begin
                              conf_done <= 1'b1;
                              init_cnt  <= '0;
                              state     <= ST_INIT;
                           end else begin
                              state <= ST_ERROR;
                           end
`else
                           conf_done <= 1'b1;
                           init_cnt  <= '0;
                           state     <= ST_INIT;
`endif
                        end
`ifdef CFG_RX_CHECKSUM_EN
                        if (!last_byte) begin
                           sum <= sum + asm_byte;
                        end
`endif
                     end
                  end
               end
               ST_INIT: begin
                  if (dclk_rise) begin
                     if (init_cnt == IW'(INIT_CLKS - 1)) begin
                        init_done <= 1'b1;
                        state     <= ST_USER;
                     end else begin
                        init_cnt <= init_cnt + IW'(1);
                     end
                  end
               end
               ST_USER: begin
               end
`ifdef CFG_RX_CHECKSUM_EN
               ST_ERROR: begin
                  status_n  <= 1'b0;
                  conf_done <= 1'b0;
                  err_q     <= 1'b1;
               end
`endif
               default: state <= ST_RESET;
            endcase
         end
      end
   end
endmodule

// File: tb/tb_fpga_ps_cfg_rx.sv
// Self-checking bench for fpga_ps_cfg_rx: a byte/phase level model of the configuration protocol
// predicts every strobe and the settled status outputs after each dclk pulse.
module tb_fpga_ps_cfg_rx;
   localparam int IMAGE_BYTES = 16;
   localparam int RST_DLY     = 100;
   localparam int INIT_CLKS   = 10;
   localparam int CW          = $clog2(IMAGE_BYTES + 1);
`ifdef CFG_RX_CHECKSUM_EN
   localparam bit CHK = 1'b1;
`else
   localparam bit CHK = 1'b0;
`endif
   localparam int P_RESET = 0, P_WAIT = 1, P_LOAD = 2, P_INIT = 3, P_USER = 4, P_ERR = 5;

   typedef struct {
      logic [7:0] b;
      logic       cd;
      int         cnt;
   } exp_t;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          config_n = 1'b1;
   logic          dclk = 1'b0;
   logic          data0 = 1'b0;
   logic          status_n, conf_done, init_done, cfg_stb, cfg_err;
   logic [7:0]    cfg_byte;
   logic [CW-1:0] byte_cnt;

   int            pass_cnt = 0;
   int            chk_cnt  = 0;
   int            stb_seen = 0;
   int            m_phase, m_bits, m_cnt, m_init;
   logic [7:0]    m_acc, m_sum, m_lastb;
   exp_t          exp_q[$];
   logic          prev_stb = 1'b0;

   fpga_ps_cfg_rx #(
      .IMAGE_BYTES(IMAGE_BYTES),
      .RST_DLY    (RST_DLY),
      .INIT_CLKS  (INIT_CLKS)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .config_n (config_n),
      .dclk     (dclk),
      .data0    (data0),
      .status_n (status_n),
      .conf_done(conf_done),
      .init_done(init_done),
      .cfg_byte (cfg_byte),
      .cfg_stb  (cfg_stb),
      .byte_cnt (byte_cnt),
      .cfg_err  (cfg_err)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
      chk_cnt++;
      if (act === req) pass_cnt++;
      else $display("[TB] FAIL %s: actual=%0h required=%0h", name, act, req);
   endtask

   task automatic checkRange(input string name, input int act, input int lo, input int hi);
      chk_cnt++;
      if (act >= lo && act <= hi) pass_cnt++;
      else $display("[TB] FAIL %s: actual=%0d required=%0d..%0d", name, act, lo, hi);
   endtask

   task automatic resetModel();
      m_phase = P_RESET;
      m_bits  = 0;
      m_cnt   = 0;
      m_init  = 0;
      m_acc   = 8'd0;
      m_sum   = 8'd0;
      m_lastb = 8'd0;
      exp_q.delete();
   endtask

   // One dclk rising edge as seen by the protocol: a data bit while loading, an init clock afterwards.
   task automatic modelBit(input logic b);
      exp_t e;
      if (m_phase == P_LOAD) begin
         m_acc[m_bits] = b;
         m_bits++;
         if (m_bits == 8) begin
            m_cnt++;
            m_lastb = m_acc;
            e.b   = m_acc;
            e.cd  = 1'b0;
            e.cnt = m_cnt;
            if (m_cnt == IMAGE_BYTES) begin
               if (CHK && m_acc != m_sum) begin
                  m_phase = P_ERR;
               end else begin
                  m_phase = P_INIT;
                  m_init  = 0;
                  e.cd    = 1'b1;
               end
            end else begin
               m_sum = m_sum + m_acc;
            end
            exp_q.push_back(e);
            m_acc  = 8'd0;
            m_bits = 0;
         end
      end else if (m_phase == P_INIT) begin
         m_init++;
         if (m_init == INIT_CLKS) m_phase = P_USER;
      end
   endtask

   task automatic checkModel(input string tag);
      checkOutput({tag, "_status_n"},  32'(status_n),  32'(m_phase == P_LOAD || m_phase == P_INIT || m_phase == P_USER));
      checkOutput({tag, "_conf_done"}, 32'(conf_done), 32'(m_phase == P_INIT || m_phase == P_USER));
      checkOutput({tag, "_init_done"}, 32'(init_done), 32'(m_phase == P_USER));
      checkOutput({tag, "_cfg_err"},   32'(cfg_err),   32'(m_phase == P_ERR));
      checkOutput({tag, "_byte_cnt"},  32'(byte_cnt),  32'(m_cnt));
      checkOutput({tag, "_cfg_byte"},  32'(cfg_byte),  32'(m_lastb));
   endtask

   task automatic applyStimulus(input logic b);
      data0 = b;
      modelBit(b);
      repeat (2) @(negedge clk);
      dclk = 1'b1;
      repeat (3) @(negedge clk);
      dclk = 1'b0;
      repeat (3) @(negedge clk);
      checkModel("pulse");
   endtask

   task automatic sendByte(input logic [7:0] v);
      for (int i = 0; i < 8; i++) applyStimulus(v[i]);
   endtask

   task automatic configLow();
      config_n = 1'b0;
      repeat (3) @(negedge clk);
      resetModel();
   endtask

   task automatic configHigh();
      config_n = 1'b1;
      m_phase  = P_WAIT;
   endtask

   task automatic waitLoad();
      int n = 0;
      while (status_n !== 1'b1 && n < RST_DLY + 20) begin
         @(negedge clk);
         n++;
      end
      checkOutput("wait_load_status_n", 32'(status_n), 32'd1);
      m_phase = P_LOAD;
   endtask

   // Strobe scoreboard: every cfg_stb must match the next byte the model completed.
   always @(negedge clk) begin : monitor
      exp_t e;
      if (!rst) begin
         checkOutput("cnt_bound", 32'(byte_cnt <= IMAGE_BYTES), 32'd1);
         if (cfg_stb) begin
            stb_seen++;
            checkOutput("stb_width", 32'(prev_stb), 32'd0);
            checkOutput("stb_expected", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) begin
               e = exp_q.pop_front();
               checkOutput("stb_byte", 32'(cfg_byte), 32'(e.b));
               checkOutput("stb_byte_cnt", 32'(byte_cnt), 32'(e.cnt));
               checkOutput("stb_conf_done", 32'(conf_done), 32'(e.cd));
            end
         end
         prev_stb = cfg_stb;
      end
   end

   initial begin : watchdog
      #2000000;
      $display("[TB] FAIL watchdog: time limit reached, pass=%0d total=%0d", pass_cnt, chk_cnt);
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin : stimulus
      int first_hi;
      int stb0;
      resetModel();
      @(negedge clk);
      checkModel("reset");
      checkOutput("reset_cfg_stb", 32'(cfg_stb), 32'd0);
      rst = 1'b0;
      m_phase = P_WAIT;

      first_hi = -1;
      for (int i = 1; i <= RST_DLY + 20; i++) begin
         @(negedge clk);
         if (status_n === 1'b1) begin
            first_hi = i;
            break;
         end
      end
      checkRange("status_n_release_cycle", first_hi, RST_DLY + 3, RST_DLY + 6);
      checkOutput("no_stb_before_load", 32'(stb_seen), 32'd0);
      m_phase = P_LOAD;

      $display("[TB] full image 0x00..0x0F");
      stb0 = stb_seen;
      for (int v = 0; v < IMAGE_BYTES; v++) sendByte(8'(v));
      checkOutput("image_stb_count", 32'(stb_seen - stb0), 32'd16);
      checkOutput("image_byte_cnt", 32'(byte_cnt), 32'd16);
      checkOutput("image_last_byte", 32'(cfg_byte), 32'h0F);
      for (int i = 0; i < INIT_CLKS; i++) applyStimulus(1'(i));
      checkModel("after_init");

      $display("[TB] extra dclk in user mode");
      stb0 = stb_seen;
      for (int i = 0; i < 8; i++) applyStimulus(1'b1);
      checkOutput("user_no_stb", 32'(stb_seen - stb0), 32'd0);
      checkOutput("user_byte_cnt", 32'(byte_cnt), 32'd16);
      configLow();
      checkModel("user_clear");

      $display("[TB] dclk activity during wait");
      configHigh();
      stb0 = stb_seen;
      for (int i = 0; i < 20; i++) begin
         data0 = 1'b1;
         dclk  = 1'b1;
         repeat (2) @(negedge clk);
         dclk  = 1'b0;
         repeat (2) @(negedge clk);
      end
      checkOutput("wait_no_stb", 32'(stb_seen - stb0), 32'd0);
      checkOutput("wait_byte_cnt", 32'(byte_cnt), 32'd0);
      checkOutput("wait_status_n", 32'(status_n), 32'd0);
      waitLoad();
      sendByte(8'hA5);
      checkOutput("first_byte_after_wait", 32'(cfg_byte), 32'hA5);
      checkOutput("first_byte_cnt", 32'(byte_cnt), 32'd1);

      $display("[TB] abort after 5 bytes and 3 bits");
      for (int v = 1; v <= 4; v++) sendByte(8'(v * 17));
      for (int i = 0; i < 3; i++) applyStimulus(1'b1);
      configLow();
      checkOutput("abort_status_n", 32'(status_n), 32'd0);
      checkOutput("abort_byte_cnt", 32'(byte_cnt), 32'd0);
      configHigh();
      waitLoad();
      stb0 = stb_seen;
      for (int v = 0; v < IMAGE_BYTES - 1; v++) sendByte(8'(v));
      sendByte(8'h69);
      checkOutput("reload_stb_count", 32'(stb_seen - stb0), 32'd16);
      checkOutput("reload_conf_done", 32'(conf_done), 32'd1);
      checkOutput("reload_cfg_err", 32'(cfg_err), 32'd0);
      checkOutput("reload_byte_cnt", 32'(byte_cnt), 32'd16);

      $display("[TB] image with zero trailing byte");
      configLow();
      configHigh();
      waitLoad();
      for (int v = 0; v < IMAGE_BYTES - 1; v++) sendByte(8'(v));
      sendByte(8'h00);
      repeat (3) @(negedge clk);
      checkModel("zero_tail");
      checkOutput("zero_tail_byte_cnt", 32'(byte_cnt), 32'd16);

      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end
endmodule
